// File: rtl/ahb_master_interface.sv
// Single-beat AHB-Lite initiator: turns a command stream into NONSEQ transfers
// with the next address phase overlapping the current data phase; in-order responses.
module ahb_master_interface #(
  parameter logic [2:0]  HSIZE_VAL = 3'b010,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        Hreadyin,
  input  logic [1:0]  Hresp,
  input  logic [31:0] Hrdata,
  output logic [31:0] Haddr,
  output logic [1:0]  Htrans,
  output logic        Hwrite,
  output logic [2:0]  Hsize,
  output logic [31:0] Hwdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        aphase_busy;
  logic        accept;
  logic        aphase_done;
  logic        dphase_done;
  logic        dphase_valid;
  logic        dphase_write;
  logic [31:0] pend_wdata;

  assign Hsize       = HSIZE_VAL;
  assign aphase_busy = (Htrans == HTRANS_NONSEQ);
  assign cmd_ready   = !aphase_busy || Hreadyin;
  assign accept      = cmd_valid && cmd_ready;
  assign aphase_done = aphase_busy && Hreadyin;
  assign dphase_done = dphase_valid && Hreadyin;

  // Address-phase slot; pending wdata rides along until the slot completes.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Htrans     <= HTRANS_IDLE;
      Haddr      <= IDLE_ADDR;
      Hwrite     <= 1'b0;
      pend_wdata <= 32'h0;
    end else if (accept) begin
      Htrans     <= HTRANS_NONSEQ;
      Haddr      <= cmd_addr;
      Hwrite     <= cmd_write;
      pend_wdata <= cmd_wdata;
    end else if (cmd_ready) begin
      Htrans <= HTRANS_IDLE;
      Haddr  <= IDLE_ADDR;
      Hwrite <= 1'b0;
    end
  end

  // Data phase: Hwdata only moves when a write leaves the address phase,
  // so it stays stable through wait states.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      dphase_valid <= 1'b0;
      dphase_write <= 1'b0;
      Hwdata       <= 32'h0;
    end else if (aphase_done) begin
      dphase_valid <= 1'b1;
      dphase_write <= Hwrite;
      if (Hwrite) Hwdata <= pend_wdata;
    end else if (dphase_done) begin
      dphase_valid <= 1'b0;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= dphase_done;
      if (dphase_done) begin
        rsp_write <= dphase_write;
        rsp_rdata <= dphase_write ? 32'h0 : Hrdata;
        rsp_error <= (Hresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_interface.sv
// Directed scenarios plus a randomized run against a transfer-level model.
module tb_ahb_master_interface;
  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        Hreadyin;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [31:0] Hwdata;
  logic        rsp_valid, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 Hclk = ~Hclk;

  ahb_master_interface dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .Hreadyin(Hreadyin), .Hresp(Hresp), .Hrdata(Hrdata), .Haddr(Haddr),
    .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  task automatic step();
    @(posedge Hclk); #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0; set_cmd(0, 0, 0, 0);
    Hreadyin = 1'b1; Hresp = 2'b00; Hrdata = 32'h0;
    step(); step();
    Hresetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    Hresetn = 1'b0; set_cmd(0, 0, 0, 0);
    Hreadyin = 1'b1; Hresp = 2'b00; Hrdata = 32'h0;
    step();
    n_cmp++; if (Htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %h want 0", Htrans); end
    n_cmp++; if (Haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", Haddr); end
    n_cmp++; if (Hwrite !== 1'b0 || Hwdata !== 32'h0) begin n_fail++; $display("FAIL rst_hwrite_hwdata: got %b/%h want 0/0", Hwrite, Hwdata); end
    n_cmp++; if ({rsp_valid, rsp_write, rsp_error} !== 3'b000 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp: got %b%b%b/%h want 000/0", rsp_valid, rsp_write, rsp_error, rsp_rdata); end
    n_cmp++; if (Hsize !== 3'b010) begin n_fail++; $display("FAIL rst_hsize: got %h want 2", Hsize); end
    Hresetn = 1'b1; step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    set_cmd(1, 1, 32'h8000_0010, 32'hDEAD_BEEF); #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready: got %b want 1", cmd_ready); end
    step(); set_cmd(0, 0, 0, 0);
    n_cmp++; if (Htrans !== 2'b10 || Haddr !== 32'h8000_0010 || Hwrite !== 1'b1) begin n_fail++; $display("FAIL sw_aphase: got %h/%h/%b want 2/80000010/1", Htrans, Haddr, Hwrite); end
    step();
    n_cmp++; if (Hwdata !== 32'hDEAD_BEEF || Htrans !== 2'b00 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_dphase: got %h/%h/%b want deadbeef/0/0", Hwdata, Htrans, rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rsp: got %b%b%b/%h want 110/0", rsp_valid, rsp_write, rsp_error, rsp_rdata); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_read_waits();
    int pulses = 0;
    set_cmd(1, 0, 32'h8400_0004, 32'h0);
    step(); set_cmd(0, 0, 0, 0);
    n_cmp++; if (Htrans !== 2'b10 || Haddr !== 32'h8400_0004 || Hwrite !== 1'b0) begin n_fail++; $display("FAIL rw_aphase: got %h/%h/%b want 2/84000004/0", Htrans, Haddr, Hwrite); end
    step();
    Hreadyin = 1'b0; Hrdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (rsp_valid) pulses++;
      n_cmp++; if (Htrans !== 2'b00 || Haddr !== 32'h0) begin n_fail++; $display("FAIL rw_hold: got %h/%h want 0/0", Htrans, Haddr); end
    end
    Hreadyin = 1'b1; Hrdata = 32'h1234_5678;
    step(); Hrdata = 32'h0;
    if (rsp_valid) pulses++;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_write !== 1'b0 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL rw_rsp: got %b/%h/%b/%b want 1/12345678/0/0", rsp_valid, rsp_rdata, rsp_write, rsp_error); end
    for (int i = 0; i < 3; i++) begin step(); if (rsp_valid) pulses++; end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL rw_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    set_cmd(1, 1, 32'h8000_0000, 32'h1111_1111); step();
    n_cmp++; if (Htrans !== 2'b10 || Haddr !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_a0: got %h/%h want 2/80000000", Htrans, Haddr); end
    set_cmd(1, 0, 32'h8800_0008, 32'h0); step();
    n_cmp++; if (Htrans !== 2'b10 || Haddr !== 32'h8800_0008 || Hwdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_a1: got %h/%h/%h want 2/88000008/11111111", Htrans, Haddr, Hwdata); end
    set_cmd(1, 1, 32'h8400_0000, 32'h3333_3333); Hrdata = 32'hA5A5_0001; step();
    n_cmp++; if (Htrans !== 2'b10 || Haddr !== 32'h8400_0000 || rsp_valid !== 1'b1 || rsp_write !== 1'b1) begin n_fail++; $display("FAIL b2b_a2: got %h/%h/%b/%b want 2/84000000/1/1", Htrans, Haddr, rsp_valid, rsp_write); end
    set_cmd(0, 0, 0, 0); step();
    n_cmp++; if (Htrans !== 2'b00 || Hwdata !== 32'h3333_3333 || rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_r1: got %h/%h/%b/%b/%h want 0/33333333/1/0/a5a50001", Htrans, Hwdata, rsp_valid, rsp_write, rsp_rdata); end
    Hrdata = 32'h0; step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_r2: got %b/%b/%h want 1/1/0", rsp_valid, rsp_write, rsp_rdata); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", rsp_valid); end
  endtask

  task automatic test_stall();
    set_cmd(1, 1, 32'h8000_0020, 32'hCAFE_0001); step();
    set_cmd(1, 0, 32'h8000_0024, 32'h0); step();
    set_cmd(1, 1, 32'h8000_0028, 32'hCAFE_0002);
    Hreadyin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready%0d: got %b want 0", i, cmd_ready); end
      step();
      n_cmp++; if (Htrans !== 2'b10 || Haddr !== 32'h8000_0024 || Hwdata !== 32'hCAFE_0001 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL st_hold%0d: got %h/%h/%h/%b want 2/80000024/cafe0001/0", i, Htrans, Haddr, Hwdata, rsp_valid); end
    end
    set_cmd(0, 0, 0, 0); Hreadyin = 1'b1; step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || Htrans !== 2'b00) begin n_fail++; $display("FAIL st_rspA: got %b/%b/%h want 1/1/0", rsp_valid, rsp_write, Htrans); end
    Hrdata = 32'h0000_0077; step(); Hrdata = 32'h0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h77) begin n_fail++; $display("FAIL st_rspB: got %b/%b/%h want 1/0/77", rsp_valid, rsp_write, rsp_rdata); end
    step();
  endtask

  task automatic test_error();
    set_cmd(1, 1, 32'h8000_0030, 32'h0BAD_F00D); step();
    set_cmd(1, 0, 32'h8000_0034, 32'h0); step();
    set_cmd(0, 0, 0, 0); Hresp = 2'b01; Hreadyin = 1'b0; step();
    n_cmp++; if (rsp_valid !== 1'b0 || Htrans !== 2'b10 || Haddr !== 32'h8000_0034) begin n_fail++; $display("FAIL er_wait: got %b/%h/%h want 0/2/80000034", rsp_valid, Htrans, Haddr); end
    Hreadyin = 1'b1; step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_write !== 1'b1) begin n_fail++; $display("FAIL er_rsp: got %b/%b/%b want 1/1/1", rsp_valid, rsp_error, rsp_write); end
    Hresp = 2'b00; Hrdata = 32'h0000_0055; step(); Hrdata = 32'h0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h55) begin n_fail++; $display("FAIL er_next: got %b/%b/%h want 1/0/55", rsp_valid, rsp_error, rsp_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    set_cmd(1, 1, 32'h8000_0040, 32'h4444_4444); step();
    set_cmd(0, 0, 0, 0); step();
    Hreadyin = 1'b0; step();
    Hresetn = 1'b0; #1;
    n_cmp++; if (Htrans !== 2'b00 || Hwdata !== 32'h0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async: got %h/%h/%b want 0/0/0", Htrans, Hwdata, rsp_valid); end
    Hreadyin = 1'b1;
    step(); if (rsp_valid) pulses++;
    Hresetn = 1'b1;
    step(); if (rsp_valid) pulses++;
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rm_dropped: got %0d pulses want 0", pulses); end
    set_cmd(1, 0, 32'h8000_0044, 32'h0); step();
    set_cmd(0, 0, 0, 0); Hrdata = 32'h600D_600D; step(); step(); Hrdata = 32'h0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h600D_600D || rsp_error !== 1'b0) begin n_fail++; $display("FAIL rm_after: got %b/%h/%b want 1/600d600d/0", rsp_valid, rsp_rdata, rsp_error); end
    step();
  endtask

  // Model tracks transfers, not bus signals: one slot waiting for its address
  // phase to finish, one waiting for its data phase, and the expected response.
  task automatic test_random();
    logic        a_v = 0, a_w = 0, d_v = 0, d_w = 0;
    logic [31:0] a_addr = 0, a_wd = 0, hwdata = 0;
    logic        e_v = 0, e_w = 0, e_err = 0;
    logic [31:0] e_rd = 0;
    logic        rdy, acc;
    int n_acc = 0, n_rsp = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_cmp++; if (Htrans !== (a_v ? 2'b10 : 2'b00) || Haddr !== (a_v ? a_addr : 32'h0) || Hwrite !== (a_v & a_w)) begin n_fail++; $display("FAIL rnd_aphase c%0d: got %h/%h/%b want %h/%h/%b", cyc, Htrans, Haddr, Hwrite, a_v ? 2'b10 : 2'b00, a_v ? a_addr : 32'h0, a_v & a_w); end
      n_cmp++; if (Hwdata !== hwdata) begin n_fail++; $display("FAIL rnd_hwdata c%0d: got %h want %h", cyc, Hwdata, hwdata); end
      n_cmp++; if (rsp_valid !== e_v || (e_v && (rsp_write !== e_w || rsp_rdata !== e_rd || rsp_error !== e_err))) begin n_fail++; $display("FAIL rnd_rsp c%0d: got %b/%b/%h/%b want %b/%b/%h/%b", cyc, rsp_valid, rsp_write, rsp_rdata, rsp_error, e_v, e_w, e_rd, e_err); end
      if (rsp_valid) n_rsp++;
      rdy = ($urandom_range(0, 3) != 0);
      Hreadyin = rdy;
      Hresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      Hrdata = $urandom;
      set_cmd(cyc < 390 && $urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom);
      #1;
      n_cmp++; if (cmd_ready !== (!a_v || rdy)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, cmd_ready, !a_v || rdy); end
      acc = cmd_valid && (!a_v || rdy);
      if (acc) n_acc++;
      e_v = d_v && rdy;
      if (e_v) begin e_w = d_w; e_rd = d_w ? 32'h0 : Hrdata; e_err = (Hresp != 2'b00); end
      if (a_v && rdy) begin d_v = 1; d_w = a_w; if (a_w) hwdata = a_wd; end
      else if (d_v && rdy) d_v = 0;
      if (acc) begin a_v = 1; a_w = cmd_write; a_addr = cmd_addr; a_wd = cmd_wdata; end
      else if (rdy || !a_v) a_v = 0;
      step();
    end
    set_cmd(0, 0, 0, 0); Hreadyin = 1'b1; Hresp = 2'b00;
    for (int i = 0; i < 4; i++) begin if (rsp_valid) n_rsp++; step(); end
    n_cmp++; if (n_rsp != n_acc) begin n_fail++; $display("FAIL rnd_count: got %0d responses want %0d", n_rsp, n_acc); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_waits();
    test_back_to_back();
    test_stall();
    test_error();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
